// File: rtl/conv_pkg.sv
// Shared widths and pipeline tag type for the 3x3 convolution MAC.
package conv_pkg;

  localparam int unsigned TAPS         = 9;
  localparam int unsigned KERNEL_WIDTH = 16;
  localparam int unsigned DATA_WIDTH   = 16;
  localparam int unsigned ACC_WIDTH    = 48;

  // Growth of a 3-term row sum and of the 3-row total over a single product.
  localparam int unsigned ROW_GROWTH   = 2;
  localparam int unsigned TREE_GROWTH  = 4;

  function automatic int unsigned prod_width(int unsigned kw, int unsigned dw);
    return kw + dw;
  endfunction

  function automatic int unsigned dot_width(int unsigned kw, int unsigned dw);
    return kw + dw + TREE_GROWTH;
  endfunction

  localparam int unsigned PROD_WIDTH = prod_width(KERNEL_WIDTH, DATA_WIDTH);
  localparam int unsigned ROW_WIDTH  = PROD_WIDTH + ROW_GROWTH;
  localparam int unsigned DOT_WIDTH  = dot_width(KERNEL_WIDTH, DATA_WIDTH);

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

endpackage

// File: rtl/conv3x3_dot9.sv
// Three-stage 9-tap signed dot product: products, row sums, total.
module conv3x3_dot9 #(
  parameter  int unsigned KERNEL_WIDTH = conv_pkg::KERNEL_WIDTH,
  parameter  int unsigned DATA_WIDTH   = conv_pkg::DATA_WIDTH,
  localparam int unsigned DOT_WIDTH    = conv_pkg::dot_width(KERNEL_WIDTH, DATA_WIDTH)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          en,
  input  conv_pkg::tag_t                                in_tag,
  input  logic [conv_pkg::TAPS*KERNEL_WIDTH-1:0]        kernel,
  input  logic [conv_pkg::TAPS*DATA_WIDTH-1:0]          window,
  output conv_pkg::tag_t                                dot_tag,
  output logic signed [DOT_WIDTH-1:0]                   dot
);
  import conv_pkg::*;

  localparam int unsigned PW = prod_width(KERNEL_WIDTH, DATA_WIDTH);
  localparam int unsigned RW = PW + ROW_GROWTH;

  logic signed [PW-1:0]        prod_c [TAPS];
  logic signed [PW-1:0]        prod_q [TAPS];
  logic signed [RW-1:0]        row_c  [3];
  logic signed [RW-1:0]        row_q  [3];
  logic signed [DOT_WIDTH-1:0] dot_c;
  tag_t                        s1_tag;
  tag_t                        s2_tag;

  // Operands are sign-extended to the full product width before multiplying.
  for (genvar t = 0; t < TAPS; t++) begin : g_tap
    assign prod_c[t] = PW'($signed(kernel[t*KERNEL_WIDTH +: KERNEL_WIDTH]))
                     * PW'($signed(window[t*DATA_WIDTH +: DATA_WIDTH]));
  end

  for (genvar r = 0; r < 3; r++) begin : g_row
    assign row_c[r] = RW'(prod_q[3*r]) + RW'(prod_q[3*r+1]) + RW'(prod_q[3*r+2]);
  end

  assign dot_c = DOT_WIDTH'(row_q[0]) + DOT_WIDTH'(row_q[1]) + DOT_WIDTH'(row_q[2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_tag  <= '0;
      s2_tag  <= '0;
      dot_tag <= '0;
      prod_q  <= '{default: '0};
      row_q   <= '{default: '0};
      dot     <= '0;
    end else if (en) begin
      s1_tag  <= in_tag;
      prod_q  <= prod_c;
      s2_tag  <= s1_tag;
      row_q   <= row_c;
      dot_tag <= s2_tag;
      dot     <= dot_c;
    end
  end

endmodule

// File: rtl/conv3x3_mac.sv
// 3x3 convolution MAC: per-channel dot products accumulated into one pixel result.
module conv3x3_mac #(
  parameter int unsigned KERNEL_WIDTH = conv_pkg::KERNEL_WIDTH,
  parameter int unsigned DATA_WIDTH   = conv_pkg::DATA_WIDTH,
  parameter int unsigned ACC_WIDTH    = conv_pkg::ACC_WIDTH
) (
  input  logic                            clk,
  input  logic                            Reset,
  input  logic [8:0]                      CHANNEL_SIZE,
  input  logic [9*KERNEL_WIDTH-1:0]       kernel_in,
  input  logic [9*DATA_WIDTH-1:0]         window_in,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [ACC_WIDTH-1:0]            out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [7:0]                      chan_idx
);
  import conv_pkg::*;

  localparam int unsigned DW = dot_width(KERNEL_WIDTH, DATA_WIDTH);

  logic                        stall;
  logic                        en;
  logic                        accept;
  logic                        first_beat;
  logic                        last_beat;
  logic [8:0]                  chan_size_q;
  logic [8:0]                  chan_eff;
  tag_t                        in_tag;
  tag_t                        dot_tag;
  logic signed [DW-1:0]        dot;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_next;

  assign stall    = out_valid && !out_ready;
  assign en       = !stall;
  assign in_ready = en;
  assign accept   = in_valid && in_ready;

  // The channel count is only live on a pixel's first beat; afterwards the held copy applies.
  always_comb begin
    first_beat = (chan_idx == 8'd0);
    chan_eff   = chan_size_q;
    if (first_beat) chan_eff = (CHANNEL_SIZE == 9'd0) ? 9'd1 : CHANNEL_SIZE;
    last_beat  = ({1'b0, chan_idx} + 9'd1) == chan_eff;
    in_tag       = '0;
    in_tag.valid = accept;
    in_tag.first = accept && first_beat;
    in_tag.last  = accept && last_beat;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      chan_idx    <= '0;
      chan_size_q <= '0;
    end else if (accept) begin
      if (first_beat) chan_size_q <= chan_eff;
      chan_idx <= last_beat ? 8'd0 : chan_idx + 8'd1;
    end
  end

  conv3x3_dot9 #(
    .KERNEL_WIDTH (KERNEL_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_dot9 (
    .clk     (clk),
    .rst     (Reset),
    .en      (en),
    .in_tag  (in_tag),
    .kernel  (kernel_in),
    .window  (window_in),
    .dot_tag (dot_tag),
    .dot     (dot)
  );

  always_comb begin
    acc_next = dot_tag.first ? ACC_WIDTH'(dot) : acc + ACC_WIDTH'(dot);
  end

  // When not stalled, any pending result is being consumed, so out_valid follows S3's last tag.
  always_ff @(posedge clk) begin
    if (Reset) begin
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      out_valid <= dot_tag.valid && dot_tag.last;
      if (dot_tag.valid) begin
        acc <= acc_next;
        if (dot_tag.last) out_data <= acc_next;
      end
    end
  end

endmodule

// File: doc/conv3x3_mac.md
CONV3X3_MAC -- requirements
Module: conv3x3_mac

Interface
REQ-001 SHALL have parameter KERNEL_WIDTH, default 16, signed weight width per tap.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, signed activation width per tap.
REQ-003 SHALL have parameter ACC_WIDTH, default 48, accumulator/output width; minimum KERNEL_WIDTH+DATA_WIDTH+12.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port Reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port CHANNEL_SIZE  input  9  input channels accumulated per output pixel, 1..256.
REQ-007 SHALL have port kernel_in  input  9*KERNEL_WIDTH  3x3 weights from kernel BRAM doutb; tap i=row*3+col at bits [W*i+W-1:W*i], row 0 top.
REQ-008 SHALL have port window_in  input  9*DATA_WIDTH  3x3 activation window, same tap packing.
REQ-009 SHALL have port in_valid  input  1  kernel_in/window_in hold one channel beat.
REQ-010 SHALL have port in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-011 SHALL have port out_data  output  ACC_WIDTH  signed sum over taps and channels.
REQ-012 SHALL have port out_valid  output  1  out_data holds a complete pixel result.
REQ-013 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready.
REQ-014 SHALL have port chan_idx  output  8  channel index of next beat to be accepted.

Function
REQ-015 SHALL compute per beat dot = sum over i of signed(kernel_in tap i) * signed(window_in tap i), full precision, no rounding/saturation.
REQ-016 SHALL register in 4 stages: S1 nine products, S2 three row sums, S3 nine-tap sum, S4 accumulator/output.
REQ-017 SHALL tag each accepted beat with first (chan_idx==0) and last (chan_idx==CHANNEL_SIZE_eff-1) flags carried through S1-S3.
REQ-018 SHALL sample CHANNEL_SIZE when a first beat is accepted, holding it for that pixel; value 0 treated as 1.
REQ-019 SHALL, in S4, load acc=dot on first, acc+=dot otherwise; sign-extend dot to ACC_WIDTH.
REQ-020 SHALL assert out_valid with out_data=final acc in cycle after S3 holds a last-tagged beat; result latency 4 cycles from last-beat acceptance.
REQ-021 SHALL define stall = out_valid && !out_ready; during stall S1-S4, tags, chan_idx freeze and in_ready=0.
REQ-022 SHALL drive in_ready = !stall; beats accepted back-to-back at 1 per cycle otherwise.
REQ-023 SHALL deassert out_valid on out_ready handshake unless new result produced same cycle; out_data stable while out_valid && !out_ready.
REQ-024 SHALL increment chan_idx on acceptance, wrap to 0 after last beat.
REQ-025 SHALL handle first and last on same beat (CHANNEL_SIZE_eff=1): out_data = that beat's dot.
REQ-026 SHALL ignore in_valid bubbles: pipeline bubbles carry no tags and do not modify acc.

Reset
REQ-027 SHALL on Reset clear chan_idx, all pipeline valids/tags, acc and out_data to 0; out_valid=0; in_ready=1 in cycle after Reset deasserts.
REQ-028 SHALL on Reset mid-pixel discard partial accumulation; next accepted beat is first of new pixel.

Structure
REQ-029 SHALL place KERNEL_WIDTH, DATA_WIDTH, TAPS=9, ACC_WIDTH defaults and product/tree width constants in shared package conv_pkg.
REQ-030 SHALL implement S1-S3 as sub-module conv3x3_dot9 (products + adder tree, with enable and tag passthrough); accumulator, counter, handshake in top.

Verification
REQ-031 SHALL cover: CHANNEL_SIZE=1, all weights 1, all window 2 -> out_data=18, out_valid 4 cycles after accept.
REQ-032 SHALL cover: CHANNEL_SIZE=256, weights 1, window 1, 256 back-to-back beats -> single result 2304, chan_idx returns 0.
REQ-033 SHALL cover: CHANNEL_SIZE=256, all taps 0x8000 both inputs -> out_data=2473901162496 (9*2^30*256), no overflow.
REQ-034 SHALL cover: out_ready low 5 cycles with result pending and in_valid high -> in_ready low 5 cycles, out_data stable, no beat lost or duplicated.
REQ-035 SHALL cover: CHANNEL_SIZE=4, Reset after 3 beats, then 4 beats weight 1 window 3 -> out_data=108, no contribution from pre-reset beats.
REQ-036 SHALL cover: CHANNEL_SIZE=0, one beat weights 2 window 5 -> out_data=90 after 1 beat.
